// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: lane placement, load extension, req/ack sequencing
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          latch_en;

  logic          misal_in;
  logic          timeout_hit;
  logic [3:0]    be_w;
  logic [31:0]   wd_w;
  logic [31:0]   shifted_w;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld_ext;

  assign misal_in = (size == 2'b11) ||
                    ((size == 2'b01) && addr[0]) ||
                    ((size == 2'b10) && (addr[1:0] != 2'b00));

  // Counter holds the number of unacked REQ cycles already completed.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    be_w = 4'b0000;
    wd_w = 32'h0;
    case (size_q)
      2'b00: begin
        be_w = 4'b0001 << addr_q[1:0];
        wd_w = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_w = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_w = {2{wdata_q[15:0]}};
      end
      default: begin
        be_w = 4'b1111;
        wd_w = wdata_q;
      end
    endcase
  end

  assign shifted_w = mem_rdata >> {addr_q[1:0], 3'b000};
  assign lane_b    = shifted_w[7:0];
  assign lane_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_ext = mem_rdata;
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   ld_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (start) begin
          latch_en = 1'b1;
          state_d  = misal_in ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = ld_ext;
          end
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Operands are captured once at acceptance so later input changes are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (latch_en) begin
      we_q    <= is_store;
      size_q  <= size;
      uns_q   <= is_unsigned;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) || (state_q == S_FAULT);
  assign misaligned = (state_q == S_FAULT);
  assign bus_err    = (state_q == S_DONE) && err_q;
  assign rdata      = rdata_q;

  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req && we_q;
  assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be     = mem_req ? be_w : 4'b0000;
  assign mem_wdata  = (mem_req && we_q) ? wd_w : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        mis;
    logic        berr;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata = 32'h0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
    .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'b00: case (a[1:0])
               2'd0: return 4'b0001;
               2'd1: return 4'b0010;
               2'd2: return 4'b0100;
               default: return 4'b1000;
             endcase
      2'b01: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00: return u ? {24'h0, b} : (b[7] ? {24'hFFFFFF, b} : {24'h0, b});
      2'b01: return u ? {16'h0, h} : (h[15] ? {16'hFFFF, h} : {16'h0, h});
      default: return d;
    endcase
  endfunction

  // One transaction; ack_at is the REQ cycle index carrying mem_ack (>= TO means never).
  task automatic run(input logic st, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_at, input logic [31:0] rd, input bit poke);
    exp_t e;
    bit   mis;
    bit   berr;
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    berr = !mis && (ack_at >= TO);
    if (!mis && !berr && !st) model_rdata = ld_model(sz, u, a, rd);
    e.mis = mis; e.berr = berr; e.rd = model_rdata;
    sb_q.push_back(e);

    start = 1'b1; is_store = st; size = sz; is_unsigned = u; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; addr = $urandom; wdata = $urandom; is_unsigned = ~u;
    if (mis) begin
      chk("fault_no_req", mem_req, 0);
      chk("fault_done", done, 1);
    end else begin
      for (int c = 0; c < TO; c++) begin
        chk("req_held", mem_req, 1);
        if (c == 0) begin
          chk("mem_addr", mem_addr, {a[31:2], 2'b00});
          chk("mem_be", mem_be, exp_be(sz, a));
          chk("mem_we", mem_we, st);
          chk("mem_wdata", mem_wdata, st ? exp_wd(sz, wd) : 32'h0);
        end
        mem_rdata = rd;
        mem_ack = (c == ack_at);
        if (poke && c == 1) begin
          start = 1'b1; is_store = ~st; size = 2'b00;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; start = 1'b0;
        if (c == ack_at) break;
      end
      chk("done_pulse", done, 1);
      chk("req_dropped", mem_req, 0);
    end
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("done_cleared", done, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", done, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("misaligned", misaligned, e.mis);
        chk("bus_err", bus_err, e.berr);
        chk("rdata", rdata, e.rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00; is_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_mis", misaligned, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0, 1'b0);
    run(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
    run(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 0, 32'h1234_F678, 1'b0);
    run(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 0, 32'h1234_F678, 1'b0);
    run(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 0, 32'h9A34_F678, 1'b0);
    run(1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h0, 2, 32'h8001_F00D, 1'b0);
    run(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 1, 32'h8001_7FFF, 1'b0);
    run(1'b0, 2'b10, 1'b1, 32'h0000_2000, 32'h0, 2, 32'h8001_7FFF, 1'b0);
    run(1'b0, 2'b01, 1'b0, 32'h0000_3001, 32'h0, 0, 32'h0, 1'b0);
    run(1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'h5555_AAAA, 0, 32'h0, 1'b0);
    run(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 0, 32'h0, 1'b0);
    run(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 99, 32'hCAFE_BABE, 1'b0);
    run(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 3, 32'h0BAD_F00D, 1'b0);

    start = 1'b1; is_store = 1'b1; size = 2'b01; addr = 32'h0000_3002; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_mid_req", mem_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_req_drop", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    model_rdata = 32'h0;
    @(posedge clk); #1;

    run(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 2, 32'h1122_3344, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    chk("end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the execute stage and the data memory port. Stores take the narrowing direction: byte or halfword data is placed onto the 32-bit bus with byte enables. Loads take the widening direction: the byte or halfword is extracted from the bus, then zero- or sign-extended to 32 bits. The unit sequences one transaction at a time over a req/ack memory handshake and reports misaligned accesses and bus timeouts.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles `mem_req` is held without `mem_ack` before the transaction is aborted. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a transaction; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- is_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte, low half or full word is used.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; holds until the next successful load.
- misaligned  out  1  valid with `done`; alignment or illegal-size fault.
- bus_err  out  1  valid with `done`; timeout fault.
- mem_req  out  1  memory request; held until acked.
- mem_we  out  1  write strobe qualifier.
- mem_addr  out  32  `{addr[31:2], 2'b00}`.
- mem_be  out  4  byte enables; bit i = bytes [8i+7:8i].
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion; sampled while `mem_req` = 1.
- mem_rdata  in  32  load data; valid in the cycle `mem_ack` = 1.

## Operation
- States: IDLE, REQ, DONE, FAULT.
- IDLE with `start`=1 latches the op, addr and wdata.
  - If size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠0: go to FAULT.
  - Otherwise go to REQ.
- REQ:
  - `mem_req`=1.
  - `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are driven from the latched values and stay stable.
  - On `mem_ack`=1: a load captures the extended result into `rdata`; go to DONE.
  - A wait counter increments each REQ cycle without ack. If TIMEOUT≠0 and the count reaches TIMEOUT, set `bus_err` and go to DONE. No `rdata` update on a timeout.
- DONE: `done`=1 for one cycle; go to IDLE.
- FAULT: `done`=1 and `misaligned`=1 for one cycle, with no memory request; go to IDLE.
- Lanes are little-endian; lane = addr[1:0].
- Store byte:
  - `mem_be` = 4'b0001 << addr[1:0].
  - `mem_wdata` = {4{wdata[7:0]}}.
- Store half:
  - `mem_be` = addr[1] ? 1100 : 0011.
  - `mem_wdata` = {2{wdata[15:0]}}.
- Store word: `mem_be`=1111, `mem_wdata`=wdata.
- Load byte: b = `mem_rdata`[8·lane+7 : 8·lane]. Extend to 32 bits by bit 7 or zero per `is_unsigned`.
- Load half: h = addr[1] ? `mem_rdata`[31:16] : `mem_rdata`[15:0]. Extend by bit 15 or zero.
- Load word: `rdata` = `mem_rdata`. `is_unsigned` is ignored.
- Loads drive `mem_be` per size as for stores, with `mem_we`=0 and `mem_wdata`=0.
- `start` while `busy`=1 is ignored. Input changes after acceptance do not affect the transaction.

## Timing
- Reset: state IDLE. All outputs 0, including `rdata`. The wait counter is cleared.
  - Reset in REQ drops `mem_req` at the same edge.
  - The aborted transaction produces no `done`.
- Minimum latency: `start` in cycle 0, `mem_req` in cycle 1, `mem_ack` in cycle 1, `done` in cycle 2, IDLE in cycle 3. The next `start` is accepted in cycle 3.
- Each additional wait cycle adds one cycle of latency.
- Fault path: `start` in cycle 0, `done`+`misaligned` in cycle 1, IDLE in cycle 2.
- Timeout: `bus_err`+`done` arrive in the cycle after the TIMEOUT-th unacked REQ cycle.
  - If `mem_ack` arrives in the same cycle the count reaches TIMEOUT, the ack wins: no `bus_err`.
- `mem_ack` outside REQ is ignored.
- `misaligned` and `bus_err` are 0 except during their `done` cycle.

## Test plan
- SB, addr=0x1003, wdata=0x000000A5, ack in the first REQ cycle -> `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1, `done` 2 cycles after `start`.
- LB signed, addr=0x2001, `mem_rdata`=0x1234F678 -> `rdata`=0xFFFFFFF6. Same access with LBU -> 0x000000F6.
- LH signed, addr=0x2002, `mem_rdata`=0x8001_7FFF -> `rdata`=0xFFFF8001. LW at 0x2000 -> 0x80017FFF.
- LH at addr=0x3001, then SW at 0x3002, then size=11 -> each gives `done`+`misaligned` 1 cycle after `start`, with `mem_req` never asserted.
- TIMEOUT=4 with `mem_ack` held low -> `mem_req` high 4 cycles, then `done`+`bus_err`, and `rdata` keeps its prior value. Ack on the 4th cycle -> no `bus_err`.
- Assert `rst` during REQ of an SH -> next cycle `mem_req`=0, `busy`=0, `rdata`=0, no `done`. A `start` pulse during `busy` is ignored.
